// File: rtl/cnn_core_scheduler.sv
// cnn_core_scheduler
// Shares NCORE cnn_top cores between NREQ job requesters. Jobs are accepted
// round-robin (one per cycle, at most one outstanding per requester), sent to
// the lowest-index idle core with a one-cycle start pulse, and each core's
// result is returned through a single valid/ready response register tagged
// with requester and core IDs.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   sched_en            gates acceptance of new jobs only
//   req_valid/req_addr  per-requester job request and image base address
//   req_ready           one-hot (or zero) grant
//   core_start          one-cycle start pulse per core
//   core_addr           image base address per core, held while core is busy
//   core_done/value     per-core completion pulse and result
//   rsp_*               response port (valid/ready, requester id, core id, value)
//   busy_cores          per-core RUN or HOLD flag
//   jobs_inflight       busy cores plus occupied response register
//
// Per-core states
//   state   | meaning
//   ST_IDLE | free, can be dispatched
//   ST_RUN  | job started, waiting for core_done
//   ST_HOLD | result captured, waiting for the response register
module cnn_core_scheduler #(
    parameter int NREQ   = 4,
    parameter int NCORE  = 2,
    parameter int ADDR_W = 16,
    parameter int OUT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sched_en,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*ADDR_W-1:0]  req_addr,
    output logic [NREQ-1:0]         req_ready,
    output logic [NCORE-1:0]        core_start,
    output logic [NCORE*ADDR_W-1:0] core_addr,
    input  logic [NCORE-1:0]        core_done,
    input  logic [NCORE*OUT_W-1:0]  core_value,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2:0]              rsp_req_id,
    output logic [1:0]              rsp_core_id,
    output logic [OUT_W-1:0]        rsp_value,
    output logic [NCORE-1:0]        busy_cores,
    output logic [2:0]              jobs_inflight
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} core_state_t;

    core_state_t      core_state [NCORE];
    logic [2:0]       slot_req   [NCORE];
    logic [OUT_W-1:0] slot_value [NCORE];
    logic [2:0]       req_ptr;
    logic [1:0]       rsp_ptr;

    logic [NCORE-1:0]  idle_vec, hold_vec, hold_hi, hold_pick;
    logic [NREQ-1:0]   req_elig, req_cand, req_hi, req_pick;
    logic              grant_found, src_found, rsp_load;
    logic [2:0]        grant_idx, src_req;
    logic [1:0]        idle_idx, src_idx;
    logic [ADDR_W-1:0] grant_addr;
    logic [OUT_W-1:0]  src_value;

    always_comb begin
        for (int c = 0; c < NCORE; c++) begin
            idle_vec[c]   = (core_state[c] == ST_IDLE);
            hold_vec[c]   = (core_state[c] == ST_HOLD);
            busy_cores[c] = (core_state[c] != ST_IDLE);
        end
    end

    // A requester stays ineligible until its result leaves the response register.
    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            req_elig[r] = !(rsp_valid && rsp_req_id == 3'(r));
            for (int c = 0; c < NCORE; c++) begin
                if (core_state[c] != ST_IDLE && slot_req[c] == 3'(r))
                    req_elig[r] = 1'b0;
            end
        end
    end

    // Round-robin: prefer candidates at or above req_ptr, else wrap to the lowest.
    always_comb begin
        req_cand    = req_valid & req_elig & {NREQ{sched_en && (|idle_vec) && !rst}};
        for (int r = 0; r < NREQ; r++)
            req_hi[r] = req_cand[r] && (r >= int'(req_ptr));
        req_pick    = (|req_hi) ? req_hi : req_cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_addr  = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (!grant_found && req_pick[r]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(r);
                grant_addr  = req_addr[r*ADDR_W +: ADDR_W];
            end
        end
        for (int r = 0; r < NREQ; r++)
            req_ready[r] = grant_found && (grant_idx == 3'(r));
    end

    always_comb begin
        idle_idx = '0;
        for (int c = NCORE - 1; c >= 0; c--)
            if (idle_vec[c]) idle_idx = 2'(c);
    end

    always_comb begin
        rsp_load = !rsp_valid || rsp_ready;
        for (int c = 0; c < NCORE; c++)
            hold_hi[c] = hold_vec[c] && (c >= int'(rsp_ptr));
        hold_pick = (|hold_hi) ? hold_hi : hold_vec;
        src_found = 1'b0;
        src_idx   = '0;
        src_req   = '0;
        src_value = '0;
        for (int c = 0; c < NCORE; c++) begin
            if (!src_found && hold_pick[c]) begin
                src_found = 1'b1;
                src_idx   = 2'(c);
                src_req   = slot_req[c];
                src_value = slot_value[c];
            end
        end
    end

    always_comb begin
        jobs_inflight = {2'b00, rsp_valid};
        for (int c = 0; c < NCORE; c++)
            jobs_inflight = jobs_inflight + {2'b00, busy_cores[c]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCORE; c++) begin
                core_state[c] <= ST_IDLE;
                slot_req[c]   <= '0;
                slot_value[c] <= '0;
            end
            core_start  <= '0;
            core_addr   <= '0;
            req_ptr     <= '0;
            rsp_ptr     <= '0;
            rsp_valid   <= 1'b0;
            rsp_req_id  <= '0;
            rsp_core_id <= '0;
            rsp_value   <= '0;
        end else begin
            core_start <= '0;
            if (grant_found)
                req_ptr <= (grant_idx == 3'(NREQ - 1)) ? 3'd0 : grant_idx + 3'd1;

            // The three transitions need IDLE, RUN and HOLD respectively, so
            // at most one applies to a core in any cycle.
            for (int c = 0; c < NCORE; c++) begin
                if (grant_found && idle_idx == 2'(c)) begin
                    core_state[c]                  <= ST_RUN;
                    slot_req[c]                    <= grant_idx;
                    core_addr[c*ADDR_W +: ADDR_W]  <= grant_addr;
                    core_start[c]                  <= 1'b1;
                end else if (core_state[c] == ST_RUN && core_done[c]) begin
                    core_state[c] <= ST_HOLD;
                    slot_value[c] <= core_value[c*OUT_W +: OUT_W];
                end else if (rsp_load && src_found && src_idx == 2'(c)) begin
                    core_state[c] <= ST_IDLE;
                end
            end

            if (rsp_load) begin
                rsp_valid <= src_found;
                if (src_found) begin
                    rsp_req_id  <= src_req;
                    rsp_core_id <= src_idx;
                    rsp_value   <= src_value;
                    rsp_ptr     <= (src_idx == 2'(NCORE - 1)) ? 2'd0 : src_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: doc/cnn_core_scheduler.md
Name: cnn_core_scheduler

Overview:
Shares a pool of NCORE cnn_top instances between NREQ job requesters in the multi-core accelerator. Each job carries an image base address. The scheduler accepts jobs in round-robin order and dispatches each to the lowest-index idle core by pulsing its start. It captures the core's value on done and returns the result, tagged with requester and core IDs, over a valid/ready response port.

Parameters:
NREQ, 4, number of requesters (2..8)
NCORE, 2, number of CNN cores (1..4)
ADDR_W, 16, image base address width
OUT_W, 32, core result width (matches cnn_top value)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
sched_en  in  1  when low, no new jobs accepted; in-flight jobs complete
req_valid  in  NREQ  per-requester job request
req_addr  in  NREQ*ADDR_W  per-requester image base address (slice i = requester i)
req_ready  out  NREQ  one-hot grant; job accepted when req_valid[i]&req_ready[i]
core_start  out  NCORE  one-cycle start pulse per core
core_addr  out  NCORE*ADDR_W  image base address per core, held while core busy
core_done  in  NCORE  per-core done pulse
core_value  in  NCORE*OUT_W  per-core result, valid in done cycle
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_req_id  out  3  requester index of response
rsp_core_id  out  2  core that produced response
rsp_value  out  OUT_W  result
busy_cores  out  NCORE  per-core busy flag
jobs_inflight  out  3  count of busy cores plus result-pending cores

Behaviour:
- Reset (async, any time, including mid-job): all outputs 0; per-core state IDLE; RR pointers 0; pending results and the output register cleared. Jobs in flight are dropped. core_done arriving after reset is ignored.
- Per-core state: IDLE -> RUN on dispatch; RUN -> HOLD on core_done; HOLD -> IDLE when the result moves to the output register.
- Outstanding limit: a requester with a job in RUN or HOLD, or whose result sits in the output register, is ineligible. This enforces at most one outstanding job per requester.
- Grant logic (combinational):
  - req_ready is one-hot or zero.
  - Asserted only if sched_en=1 and at least one core is IDLE.
  - The winner is the first eligible requester with req_valid, scanning from req_ptr upward with wrap.
- On accept in cycle N:
  - Target is the lowest-index IDLE core.
  - Requester id and addr are latched into the core slot; the core goes to RUN.
  - req_ptr becomes winner+1 mod NREQ.
  - core_start[c]=1 in cycle N+1 only; core_addr[c] is valid from N+1 until the core leaves HOLD.
- At most one dispatch per cycle.
- core_done[c] while in RUN: core_value is latched the same edge and the core goes to HOLD. core_done while IDLE or HOLD is ignored.
- Output register:
  - Loads when (!rsp_valid || rsp_ready).
  - Source is the first HOLD core scanning from rsp_ptr; rsp_ptr then becomes c+1 mod NCORE.
  - rsp_* fields are stable while rsp_valid=1 and rsp_ready=0.
  - Back-to-back responses are possible: pop and load in the same cycle.
- Latency:
  - done at edge D gives HOLD after D.
  - If the output register is free, rsp_valid=1 after edge D+1.
  - The core is IDLE (re-dispatchable) after edge D+1.
- Simultaneous done on multiple cores: all latch; responses drain one per cycle in RR order.
- A core freed in cycle K can be granted in cycle K+1 (grant uses registered IDLE state).
- jobs_inflight = popcount(RUN|HOLD) + rsp_valid.
- sched_en low: req_ready=0; dispatch, completion and responses are unaffected.

Test Plan:
1. Reset then single job: req_valid[2]=1, addr=0x0100 → req_ready[2]=1 that cycle; core_start[0] pulses next cycle with core_addr[0]=0x0100. Drive core_done[0] with value=37 → rsp_valid with rsp_req_id=2, rsp_core_id=0, rsp_value=37 two edges after done.
2. All 4 requesters valid, 2 cores, instant done → grants in order 0,1 (cores 0,1). After responses drain, grants go to 2,3. No requester is granted twice while outstanding.
3. Backpressure: rsp_ready=0, both cores done same cycle (values 5, 9) → rsp holds 5 stable; the core 1 result stays HOLD and busy_cores=2'b10. rsp_ready=1 → 5 then 9 on consecutive cycles. jobs_inflight goes 2→1→0.
4. sched_en=0 with req_valid=4'b1111 → req_ready=0 for 20 cycles and no core_start. sched_en=1 → grant to requester 0 next cycle.
5. Spurious core_done[1] while core 1 is IDLE → no rsp_valid and state unchanged.
6. Assert rst while core 0 is in RUN and rsp_valid=1 → all outputs 0 asynchronously. A later core_done[0] produces no response, and a new job dispatches normally to core 0.
